// File: rtl/dram_arb.sv
// dram_arb: two-master arbiter and sequencer for the byte-lane data RAM.
// Master 0 (CPU load/store unit) has fixed priority over master 1 (debug/loader).
// A starvation guard hands the bus to master 1 after STARVE_MAX back-to-back
// master-0 grants that happened while master 1 was waiting.
// One transaction at a time: IDLE arbitrates, ACCESS holds the command on the
// slave port until s_ready or timeout, DONE pulses the registered ack.
module dram_arb #(
   parameter int TIMEOUT    = 15,
   parameter int STARVE_MAX = 4
) (
   input  logic        cpu_clk,
   input  logic        rst,
   input  logic        m0_req,
   input  logic        m0_we,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic [2:0]  m0_mem_op,
   output logic        m0_ack,
   output logic [31:0] m0_rdata,
   output logic        m0_err,
   input  logic        m1_req,
   input  logic        m1_we,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [2:0]  m1_mem_op,
   output logic        m1_ack,
   output logic [31:0] m1_rdata,
   output logic        m1_err,
   output logic        s_en,
   output logic        s_we,
   output logic        s_re,
   output logic [31:0] s_addr,
   output logic [31:0] s_wdata,
   output logic [2:0]  s_mem_op,
   input  logic [31:0] s_rdata,
   input  logic        s_ready,
   output logic        busy,
   output logic        grant_id
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
   localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      DONE
   } state_t;

   state_t          state;
   state_t          next_state;
   logic [TW-1:0]   tmo_cnt;
   logic [SW-1:0]   starve_cnt;
   logic            cmd_we;

   logic            grant_m0;
   logic            grant_m1;
   logic            sel_we;
   logic [31:0]     sel_addr;
   logic [31:0]     sel_wdata;
   logic [2:0]      sel_op;
   logic            finish;
   logic            fin_id;
   logic            fin_err;
   logic [31:0]     fin_rdata;

   // Only the byte, half, word and unsigned byte/half codes reach the slave.
   function automatic logic op_legal(input logic [2:0] op);
      case (op)
         3'd0, 3'd1, 3'd2, 3'd4, 3'd5: op_legal = 1'b1;
         default:                      op_legal = 1'b0;
      endcase
   endfunction

   // Arbitration, next-state and completion decode.
   always_comb begin
      next_state = state;
      grant_m0   = 1'b0;
      grant_m1   = 1'b0;
      sel_we     = m0_we;
      sel_addr   = m0_addr;
      sel_wdata  = m0_wdata;
      sel_op     = m0_mem_op;
      finish     = 1'b0;
      fin_id     = grant_id;
      fin_err    = 1'b0;
      fin_rdata  = '0;
      case (state)
         IDLE: begin
            if (m1_req && (!m0_req || (starve_cnt == STARVE_LIM))) begin
               grant_m1 = 1'b1;
            end else if (m0_req) begin
               grant_m0 = 1'b1;
            end
            if (grant_m1) begin
               sel_we    = m1_we;
               sel_addr  = m1_addr;
               sel_wdata = m1_wdata;
               sel_op    = m1_mem_op;
            end
            if (grant_m0 || grant_m1) begin
               if (op_legal(sel_op)) begin
                  next_state = ACCESS;
               end else begin
                  next_state = DONE;
                  finish     = 1'b1;
                  fin_id     = grant_m1;
                  fin_err    = 1'b1;
               end
            end
         end
         ACCESS: begin
            if (s_ready) begin
               next_state = DONE;
               finish     = 1'b1;
               fin_rdata  = cmd_we ? 32'd0 : s_rdata;
            end else if (tmo_cnt == TMO_LAST) begin
               next_state = DONE;
               finish     = 1'b1;
               fin_err    = 1'b1;
            end
         end
         DONE: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge cpu_clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Command fields are captured only on a grant and held until the next one.
   always_ff @(posedge cpu_clk) begin
      if (rst) begin
         s_addr   <= '0;
         s_wdata  <= '0;
         s_mem_op <= '0;
         cmd_we   <= 1'b0;
         grant_id <= 1'b0;
      end else if (grant_m0 || grant_m1) begin
         s_addr   <= sel_addr;
         s_wdata  <= sel_wdata;
         s_mem_op <= sel_op;
         cmd_we   <= sel_we;
         grant_id <= grant_m1;
      end
   end

   // Timeout counter runs from zero for each cycle spent in ACCESS.
   always_ff @(posedge cpu_clk) begin
      if (rst) begin
         tmo_cnt <= '0;
      end else if (state == ACCESS) begin
         tmo_cnt <= tmo_cnt + TW'(1);
      end else begin
         tmo_cnt <= '0;
      end
   end

   // Starvation counter: m0 grants made while m1 waits, saturating at the limit.
   always_ff @(posedge cpu_clk) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (!m1_req || grant_m1) begin
         starve_cnt <= '0;
      end else if (grant_m0 && (starve_cnt != STARVE_LIM)) begin
         starve_cnt <= starve_cnt + SW'(1);
      end
   end

   // Master 0 response: one-cycle ack, result held until its next ack.
   always_ff @(posedge cpu_clk) begin
      if (rst) begin
         m0_ack   <= 1'b0;
         m0_rdata <= '0;
         m0_err   <= 1'b0;
      end else begin
         m0_ack <= finish && !fin_id;
         if (finish && !fin_id) begin
            m0_rdata <= fin_rdata;
            m0_err   <= fin_err;
         end
      end
   end

   // Master 1 response: one-cycle ack, result held until its next ack.
   always_ff @(posedge cpu_clk) begin
      if (rst) begin
         m1_ack   <= 1'b0;
         m1_rdata <= '0;
         m1_err   <= 1'b0;
      end else begin
         m1_ack <= finish && fin_id;
         if (finish && fin_id) begin
            m1_rdata <= fin_rdata;
            m1_err   <= fin_err;
         end
      end
   end

   assign s_en = (state == ACCESS);
   assign s_we = s_en && cmd_we;
   assign s_re = s_en && !cmd_we;
   assign busy = (state != IDLE);

endmodule

// File: tb/tb_dram_arb.sv
// tb_dram_arb: directed self-checking bench for dram_arb with a small slave
// model (writes ready the same cycle, reads ready one cycle after enable,
// optional stuck mode that never asserts ready).
module tb_dram_arb;

   logic        cpu_clk = 1'b0;
   logic        rst;
   logic        m0_req, m0_we;
   logic [31:0] m0_addr, m0_wdata;
   logic [2:0]  m0_mem_op;
   logic        m0_ack, m0_err;
   logic [31:0] m0_rdata;
   logic        m1_req, m1_we;
   logic [31:0] m1_addr, m1_wdata;
   logic [2:0]  m1_mem_op;
   logic        m1_ack, m1_err;
   logic [31:0] m1_rdata;
   logic        s_en, s_we, s_re, s_ready, busy, grant_id;
   logic [31:0] s_addr, s_wdata, s_rdata;
   logic [2:0]  s_mem_op;

   logic        stuck;
   logic        rd_pend;
   logic [31:0] mem [1024];

   int checks = 0;
   int errors = 0;

   dram_arb #(.TIMEOUT(15), .STARVE_MAX(4)) dut (
      .cpu_clk(cpu_clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_mem_op(m0_mem_op), .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_mem_op(m1_mem_op), .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
      .s_en(s_en), .s_we(s_we), .s_re(s_re), .s_addr(s_addr), .s_wdata(s_wdata),
      .s_mem_op(s_mem_op), .s_rdata(s_rdata), .s_ready(s_ready),
      .busy(busy), .grant_id(grant_id)
   );

   always #5 cpu_clk = ~cpu_clk;

   assign s_ready = !stuck && s_en && (s_we || rd_pend);
   assign s_rdata = mem[s_addr[11:2]];

   // Slave model: read-latency flag and word memory updated on completed writes.
   always @(posedge cpu_clk) begin
      if (rst || !s_en) begin
         rd_pend <= 1'b0;
      end else begin
         rd_pend <= s_re && !rd_pend && !stuck;
      end
      if (s_en && s_we && s_ready) begin
         mem[s_addr[11:2]] <= s_wdata;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge cpu_clk);
         #1;
      end
   endtask

   task automatic applyStimulus(input logic mst, input logic req, input logic we,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [2:0] op);
      if (mst == 1'b0) begin
         m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_mem_op = op;
      end else begin
         m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_mem_op = op;
      end
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Guard against a hung run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed no completion expected $finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed sequence.
   initial begin
      int seq [6];
      int nacks;
      for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
      rst   = 1'b1;
      stuck = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
      tick(2);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_s_en", 32'(s_en), 32'd0);
      checkOutput("reset_ack", 32'({m0_ack, m1_ack}), 32'd0);
      checkOutput("reset_grant", 32'(grant_id), 32'd0);
      checkOutput("reset_s_addr", s_addr, 32'd0);
      rst = 1'b0;
      tick(1);

      $display("[TB] store then load on m0");
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 3'd2);
      tick(1);
      checkOutput("st_s_en", 32'({s_en, s_we, s_re}), 32'b110);
      checkOutput("st_s_addr", s_addr, 32'h100);
      checkOutput("st_s_wdata", s_wdata, 32'hDEADBEEF);
      checkOutput("st_ack_early", 32'(m0_ack), 32'd0);
      tick(1);
      checkOutput("st_ack", 32'({m0_ack, m0_err}), 32'b10);
      checkOutput("st_s_en_done", 32'(s_en), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h100, 32'd0, 3'd2);
      tick(1);
      checkOutput("st_idle", 32'({busy, m0_ack}), 32'd0);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h100, 32'd0, 3'd2);
      tick(1);
      checkOutput("ld_s_re", 32'({s_en, s_we, s_re}), 32'b101);
      tick(1);
      checkOutput("ld_ack_early", 32'(m0_ack), 32'd0);
      tick(1);
      checkOutput("ld_ack", 32'({m0_ack, m0_err}), 32'b10);
      checkOutput("ld_rdata", m0_rdata, 32'hDEADBEEF);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h100, 32'd0, 3'd2);
      tick(1);

      $display("[TB] timeout on m0 load");
      stuck = 1'b1;
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h100, 32'd0, 3'd2);
      tick(1);
      checkOutput("to_s_en", 32'(s_en), 32'd1);
      tick(14);
      checkOutput("to_wait", 32'({busy, s_en, m0_ack}), 32'b110);
      tick(1);
      checkOutput("to_ack", 32'({m0_ack, m0_err}), 32'b11);
      checkOutput("to_rdata", m0_rdata, 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h100, 32'd0, 3'd2);
      tick(1);
      checkOutput("to_idle", 32'({busy, m0_ack, m0_err}), 32'b001);
      stuck = 1'b0;

      $display("[TB] simultaneous requests");
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h200, 32'h11111111, 3'd2);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h200, 32'd0, 3'd2);
      tick(1);
      checkOutput("pr_grant0", 32'(grant_id), 32'd0);
      checkOutput("pr_addr0", s_addr, 32'h200);
      tick(1);
      checkOutput("pr_ack0", 32'({m0_ack, m1_ack}), 32'b10);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd2);
      tick(1);
      checkOutput("pr_idle", 32'(busy), 32'd0);
      tick(1);
      checkOutput("pr_grant1", 32'({grant_id, s_en, s_re}), 32'b111);
      tick(2);
      checkOutput("pr_ack1", 32'({m0_ack, m1_ack, m1_err}), 32'b010);
      checkOutput("pr_rdata1", m1_rdata, 32'h11111111);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 3'd2);
      tick(1);

      $display("[TB] illegal op on m1");
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h600, 32'd0, 3'd3);
      tick(1);
      checkOutput("il_ack", 32'({m1_ack, m1_err, s_en}), 32'b110);
      checkOutput("il_rdata", m1_rdata, 32'd0);
      checkOutput("il_busy_op", 32'({busy, grant_id, s_mem_op}), 32'b11011);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 3'd2);
      tick(1);
      checkOutput("il_idle", 32'({busy, m1_ack, s_en}), 32'd0);

      $display("[TB] starvation guard");
      applyStimulus(1'b1, 1'b1, 1'b1, 32'h400, 32'h33333333, 3'd2);
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h500, 32'h44444444, 3'd2);
      nacks = 0;
      for (int c = 0; c < 40 && nacks < 6; c++) begin
         tick(1);
         if (m0_ack) begin
            seq[nacks] = 0;
            nacks++;
         end
         if (m1_ack) begin
            seq[nacks] = 1;
            nacks++;
            m1_req = 1'b0;
         end
      end
      checkOutput("sv_nacks", 32'(nacks), 32'd6);
      for (int k = 0; k < 6; k++) begin
         checkOutput($sformatf("sv_order%0d", k), 32'(seq[k]), (k == 4) ? 32'd1 : 32'd0);
      end
      m0_req = 1'b0;
      for (int c = 0; c < 10 && busy; c++) tick(1);
      checkOutput("sv_drain", 32'(busy), 32'd0);
      tick(1);

      $display("[TB] reset during access");
      stuck = 1'b1;
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h700, 32'h55555555, 3'd2);
      tick(2);
      checkOutput("rs_in_access", 32'({busy, s_en}), 32'b11);
      rst = 1'b1;
      tick(1);
      checkOutput("rs_ctrl", 32'({busy, s_en, s_we, s_re, grant_id, m0_ack, m1_ack}), 32'd0);
      checkOutput("rs_addr", s_addr, 32'd0);
      checkOutput("rs_wdata", s_wdata, 32'd0);
      rst   = 1'b0;
      stuck = 1'b0;
      tick(1);
      checkOutput("rs_regrant", 32'({s_en, s_we}), 32'b11);
      checkOutput("rs_regrant_addr", s_addr, 32'h700);
      tick(1);
      checkOutput("rs_ack", 32'({m0_ack, m0_err}), 32'b10);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd2);
      tick(1);
      checkOutput("rs_idle", 32'(busy), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
